score_bcd_scan: RTL

- Upstream stage of the single-digit BCD-to-7-segment decoder in the Catch-The-Light display path.
- Holds the player score as a saturating multi-digit BCD counter, incremented by hit pulses from the game FSM.
- Time-multiplexes the score digits onto one 4-bit BCD bus that feeds the decoder.
- Drives the active-low digit anodes, with leading-zero blanking.

---
 rtl/score_bcd_scan_if.sv | 23 ++
 rtl/score_bcd_scan.sv | 115 +++++++++++
 2 files changed

// File: rtl/score_bcd_scan_if.sv
// Score/display bundle between the game FSM, the score scanner and the 7-segment decoder.
// master = game side (drives clear/inc), slave = score_bcd_scan.
interface score_bcd_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      clear;
    logic                      inc;
    logic [3:0]                BCD_out;
    logic [NUM_DIGITS-1:0]     an;
    logic [4*NUM_DIGITS-1:0]   score;
    logic                      score_max;
    logic                      overflow;

    modport master (
        output clear, inc,
        input  BCD_out, an, score, score_max, overflow
    );

    modport slave (
        input  clear, inc,
        output BCD_out, an, score, score_max, overflow
    );
endinterface

// File: rtl/score_bcd_scan.sv
// Saturating multi-digit BCD score counter with a time-multiplexed digit scan
// (one BCD nibble bus plus active-low anodes with leading-zero blanking).
module score_bcd_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    score_bcd_scan_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [4*NUM_DIGITS-1:0] r_score;
    logic                    r_overflow;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [3:0]              r_bcd;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [4*NUM_DIGITS-1:0] w_score_inc;
    logic                    w_score_max;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [3:0]              w_digit_sel;

    // Decimal ripple carry: a 9 receiving a carry rolls to 0 and passes it on.
    always_comb begin : incr
        logic carry;
        w_score_inc = r_score;
        carry       = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_score_max = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_score[4*i +: 4] != 4'd9) w_score_max = 1'b0;
        end
    end

    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin : blank
        logic zero_above;
        w_blank    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (r_score[4*i +: 4] == 4'd0);
            w_blank[i] = zero_above;
        end
    end

    always_comb begin
        w_digit_sel = 4'd0;
        w_an_next   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit_sel = r_score[4*i +: 4];
                if (!w_blank[i]) w_an_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_score    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.inc) begin
            if (w_score_max) r_overflow <= 1'b1;
            else             r_score    <= w_score_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd <= 4'd0;
            r_an  <= '1;
        end else begin
            r_bcd <= w_digit_sel;
            r_an  <= w_an_next;
        end
    end

    assign bus.score     = r_score;
    assign bus.score_max = w_score_max;
    assign bus.overflow  = r_overflow;
    assign bus.BCD_out   = r_bcd;
    assign bus.an        = r_an;
endmodule
